// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: owns the fetch PC, issues word requests to imem and
// buffers returned words with their PCs in a small FIFO presented to fetch/decode.
module instr_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  pcBranch,
    input  logic                         originPc,
    output logic                         imem_req,
    output logic [31:0]                  imem_addr,
    input  logic                         imem_gnt,
    input  logic [31:0]                  imem_data,
    output logic [31:0]                  inst,
    output logic [31:0]                  inst_pc,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fpc;
    logic [31:0]   resp_pc;
    logic          inflight;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   word_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [CW:0]   credits;
    logic          grant;
    logic          push;
    logic          pop;
    logic          unused_pc_lsbs;

    // Misaligned branch targets are truncated, so the low bits are never looked at.
    assign unused_pc_lsbs = ^pcBranch[1:0];

    // Issue is credit-limited: a word in flight reserves a slot, so a push never hits a full FIFO.
    assign credits   = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign imem_req  = reset & ~originPc & (credits < (CW+1)'(DEPTH));
    assign imem_addr = fpc;
    assign grant     = imem_req & imem_gnt;
    assign push      = inflight & ~originPc;
    assign pop       = inst_valid & inst_ready & ~originPc;

    assign inst_valid = (count != '0);
    assign inst       = word_mem[rd_ptr];
    assign inst_pc    = pc_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr] <= imem_data;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

    // A redirect wins over everything: the buffer, the in-flight response and any pop are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc      <= RESET_PC;
            resp_pc  <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (originPc) begin
            fpc      <= {pcBranch[31:2], 2'b00};
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= grant;
            if (grant) begin
                resp_pc <= fpc;
                fpc     <= fpc + 32'd4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: a scoreboard of expected fetch PCs checks every
// consumed head word, plus explicit checks of reset, credit, redirect and stall behaviour.
module tb_instr_prefetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic [31:0] pcBranch;
    logic        originPc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic [31:0] imem_data;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [2:0]  count;

    int          checks;
    int          failures;
    int          consumed;
    int          base;
    logic [31:0] exp_q [$];

    instr_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .pcBranch   (pcBranch),
        .originPc   (originPc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_data  (imem_data),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers one cycle after an accepted request; anything else returns a poison word.
    always @(posedge clk) begin
        imem_data <= (imem_req && imem_gnt) ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_stream(input logic [31:0] start);
        logic [31:0] pc;
        exp_q.delete();
        pc = start;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(pc);
            pc = pc + 32'd4;
        end
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Score any head consumed this cycle, then move past the next rising edge.
    task automatic advance();
        logic [31:0] exp_pc;
        if (inst_valid && inst_ready && !originPc) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_pc = exp_q.pop_front();
                check("sb_pc", inst_pc, exp_pc);
                check("sb_data", inst, exp_pc ^ KEY);
            end
            consumed++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        consumed   = 0;
        reset      = 1'b0;
        originPc   = 1'b0;
        pcBranch   = 32'h0;
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;

        sample();
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        advance();

        // Reset/fill: stream from address 0 at one word per cycle.
        expect_stream(32'h0);
        reset = 1'b1;
        sample();
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, 32'h0);
        check("c0_valid", 32'(inst_valid), 32'd0);
        advance();
        sample();
        check("c1_valid", 32'(inst_valid), 32'd0);
        advance();
        sample();
        check("c2_valid", 32'(inst_valid), 32'd1);
        check("c2_pc", inst_pc, 32'h0);
        advance();
        cycle(5);
        check("fill_throughput", 32'(consumed), 32'd6);

        // Backpressure: buffer saturates and issue stops.
        inst_ready = 1'b0;
        cycle(9);
        sample();
        check("bp_count", 32'(count), 32'd4);
        check("bp_req", 32'(imem_req), 32'd0);
        check("bp_head", inst_pc, 32'h18);
        advance();
        inst_ready = 1'b1;
        base = consumed;
        cycle(8);
        check("bp_drain", 32'(consumed - base), 32'd8);

        // Redirect while a response is in flight.
        originPc = 1'b1;
        pcBranch = 32'h0000_0103;
        expect_stream(32'h100);
        sample();
        check("rd_req_r", 32'(imem_req), 32'd0);
        advance();
        originPc = 1'b0;
        sample();
        check("rd_count_r1", 32'(count), 32'd0);
        check("rd_valid_r1", 32'(inst_valid), 32'd0);
        check("rd_req_r1", 32'(imem_req), 32'd1);
        check("rd_addr_r1", imem_addr, 32'h100);
        advance();
        sample();
        check("rd_valid_r2", 32'(inst_valid), 32'd0);
        advance();
        sample();
        check("rd_valid_r3", 32'(inst_valid), 32'd1);
        check("rd_pc_r3", inst_pc, 32'h100);
        advance();

        // Simultaneous push and pop at count 2.
        originPc   = 1'b1;
        pcBranch   = 32'h200;
        inst_ready = 1'b0;
        expect_stream(32'h200);
        cycle(1);
        originPc = 1'b0;
        cycle(3);
        inst_ready = 1'b1;
        imem_gnt   = 1'b0;
        sample();
        check("pp_count_before", 32'(count), 32'd2);
        advance();
        inst_ready = 1'b0;
        sample();
        check("pp_count_after", 32'(count), 32'd2);
        check("pp_head", inst_pc, 32'h204);
        advance();

        // Redirect together with a pop: the pop must be ignored.
        originPc   = 1'b1;
        pcBranch   = 32'h40;
        inst_ready = 1'b1;
        expect_stream(32'h40);
        base = consumed;
        sample();
        check("rp_req", 32'(imem_req), 32'd0);
        advance();
        originPc   = 1'b0;
        inst_ready = 1'b0;
        sample();
        check("rp_count", 32'(count), 32'd0);
        check("rp_valid", 32'(inst_valid), 32'd0);
        check("rp_no_pop", 32'(consumed - base), 32'd0);
        advance();

        // Grant stall at 0x40.
        cycle(1);
        sample();
        check("gs_req", 32'(imem_req), 32'd1);
        check("gs_addr_hold", imem_addr, 32'h40);
        advance();
        imem_gnt = 1'b1;
        sample();
        check("gs_addr_grant", imem_addr, 32'h40);
        advance();
        sample();
        check("gs_addr_next", imem_addr, 32'h44);
        advance();
        inst_ready = 1'b1;
        cycle(6);

        // Address wrap past the top of memory.
        originPc = 1'b1;
        pcBranch = 32'hFFFF_FFF8;
        expect_stream(32'hFFFF_FFF8);
        cycle(1);
        originPc = 1'b0;
        base = consumed;
        cycle(6);
        check("wrap_consumed", 32'(consumed - base), 32'd4);

        // Asynchronous reset in the middle of a cycle.
        #2;
        check("ar_valid_before", 32'(inst_valid), 32'd1);
        check("ar_req_before", 32'(imem_req), 32'd1);
        reset = 1'b0;
        #1;
        check("ar_valid", 32'(inst_valid), 32'd0);
        check("ar_req", 32'(imem_req), 32'd0);
        check("ar_count", 32'(count), 32'd0);
        cycle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_prefetch.md
# instr_prefetch

Instruction prefetch stage sitting directly upstream of the fetch/decode stage. Owns the fetch PC, issues word requests to instruction memory and buffers returned words with their PCs in a small FIFO. The FIFO head is presented to fetch/decode through a valid/ready handshake. A taken branch from execute (`originPc`/`pcBranch`) flushes the buffer, discards any in-flight response and restarts fetching at the branch target.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; word aligned.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pcBranch`  in  32  redirect target from execute.
- `originPc`  in  1  redirect strobe from execute; 1 = taken branch this cycle.
- `imem_req`  out  1  request valid to instruction memory.
- `imem_addr`  out  32  word address of request; bits [1:0] always 0.
- `imem_gnt`  in  1  memory accepts request this cycle.
- `imem_data`  in  32  instruction word; valid exactly one cycle after an accepted request.
- `inst`  out  32  FIFO head instruction.
- `inst_pc`  out  32  PC of `inst`.
- `inst_valid`  out  1  FIFO non-empty.
- `inst_ready`  in  1  fetch/decode consumes head when `inst_valid & inst_ready`.
- `count`  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- State: `fpc` (32), `inflight` (1), FIFO storage of {word, pc} × DEPTH, read/write pointers, `count`, `resp_pc` (32, PC of the in-flight request).
- Issue: `imem_req = reset & ~originPc & (count + inflight < DEPTH)`. `imem_addr = fpc`.
- On `imem_req & imem_gnt`: `resp_pc <= fpc`, `fpc <= fpc + 4` (modulo 2^32, 32'hFFFF_FFFC wraps to 0), `inflight <= 1`. Otherwise `inflight <= 0`.
- Response: when `inflight = 1` and `originPc = 0`, push {`imem_data`, `resp_pc`} at end of cycle.
- Pop: when `inst_valid & inst_ready & ~originPc`, advance read pointer.
- Simultaneous push and pop: both occur; `count` unchanged. A push into a full FIFO cannot occur, because issue is credit-limited by `count + inflight`. Same-cycle pop does not free a credit.
- Redirect (`originPc = 1`) has priority over everything:
  - pointers and `count` cleared;
  - `inflight <= 0`;
  - the response arriving this cycle is discarded;
  - no request is issued this cycle;
  - `fpc <= {pcBranch[31:2], 2'b00}`;
  - a pop attempted in the same cycle is ignored.
- `inst`, `inst_pc`: combinational from the FIFO head. Value is don't-care when `inst_valid = 0`.
- Misaligned `pcBranch` is silently truncated to word alignment. No exception path.

## Timing
- Reset (async, `reset = 0`): `fpc = RESET_PC`, `inflight = 0`, `count = 0`, `inst_valid = 0`, `imem_req = 0`, pointers 0. `inst`/`inst_pc` don't-care. Reset asserted mid-operation drops all buffered and in-flight words immediately.
- After deassertion, cycle 0: `imem_req = 1`, `imem_addr = RESET_PC`.
- Fill latency, with grant in cycle N: data sampled in N+1; `inst_valid = 1` in N+2.
- Redirect latency, with `originPc` in cycle R:
  - `imem_req = 0` in R;
  - request to the target in R+1;
  - target instruction valid at the head in R+3 (if granted in R+1).
- Throughput: with `imem_gnt` and `inst_ready` tied high, steady state delivers 1 instruction/cycle once primed.
- `imem_gnt` low: request holds the same `imem_addr` until granted. `fpc` does not advance.

## Test plan
- Reset/fill: release reset with `RESET_PC = 0`, gnt=1, memory returns `addr ^ 32'hA5A5_0000`, ready=1. Required: `inst_pc` sequence 0,4,8,C… from cycle 2, one per cycle, with the matching data.
- Backpressure: ready=0 for 10 cycles. Required: `count` saturates at 4; `imem_req` drops to 0; no word is lost or duplicated when ready returns to 1.
- Redirect with in-flight data: assert `originPc` with `pcBranch = 32'h0000_0103` while a response is in flight. Required:
  - the in-flight word is dropped;
  - `count` = 0 next cycle;
  - `imem_addr = 32'h100` in R+1;
  - `inst_pc = 32'h100` valid in R+3.
- Simultaneous push/pop at `count = 2`. Required: `count` stays 2, order preserved. Also assert `originPc` together with pop: required FIFO empty, no pop counted.
- Grant stall: gnt=0 for 3 cycles at `fpc = 32'h40`. Required: `imem_addr` holds 32'h40; after gnt=1 the next address is 32'h44.
- Wrap and async reset: redirect to 32'hFFFF_FFF8. Required: PCs FFFF_FFF8, FFFF_FFFC, 0000_0000. Then assert reset mid-cycle: required `inst_valid` and `imem_req` go 0 without waiting for a clock edge.
